// File: rtl/contador_pkg.sv
// Shared types and sizing helpers for the parametrised push-button counter.
package contador_pkg;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // Debounce counter must be able to hold the value DEBOUNCE_CYC itself.
   function automatic int deb_cnt_width(input int debounce_cyc);
      if (debounce_cyc < 1) begin
         return 1;
      end else begin
         return $clog2(debounce_cyc + 1);
      end
   endfunction

endpackage

// File: rtl/contador_param_antirrebote.sv
// Two-flop synchroniser, stable-window debouncer and registered rise detector
// for a raw push-button level.
module antirrebote
   import contador_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic reset_i,
   input  logic raw,
   output logic nivel,
   output logic pulso
);

   localparam int CW = deb_cnt_width(DEBOUNCE_CYC);
   localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CERO  = {CW{1'b0}};
   localparam logic [CW-1:0] UNO   = CW'(1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cuenta;
   logic [CW-1:0] cuenta_nxt;
   logic          nivel_nxt;
   logic          subida;

   // raw is asynchronous: only these two flops ever see it
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // A disagreeing level must persist for the full window before it is accepted
   always_comb begin
      nivel_nxt  = nivel;
      cuenta_nxt = cuenta;
      if (sync_b != nivel) begin
         if (cuenta == LIMIT) begin
            nivel_nxt  = ~nivel;
            cuenta_nxt = CERO;
         end else begin
            nivel_nxt  = nivel;
            cuenta_nxt = cuenta + UNO;
         end
      end else begin
         nivel_nxt  = nivel;
         cuenta_nxt = CERO;
      end
      subida = nivel_nxt & ~nivel;
   end

   // Debounce state and the press pulse are registered together
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         nivel  <= 1'b0;
         cuenta <= CERO;
         pulso  <= 1'b0;
      end else begin
         nivel  <= nivel_nxt;
         cuenta <= cuenta_nxt;
         pulso  <= subida;
      end
   end

endmodule

// File: rtl/contador_param.sv
// Debounced push-button up/down counter with load, wrap/saturate limits and
// a one-cycle overflow flag.
module contador_param
   import contador_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEBOUNCE_CYC = 4,
   parameter bit SATURATE     = 1'b0
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             boton_i,
   input  logic             dir_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] dato_i,
   output logic [WIDTH-1:0] conta_o,
   output logic             pulso_o,
   output logic             ovf_o
);

   localparam logic [WIDTH-1:0] MAXIMO = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] UNO    = WIDTH'(1);

   logic             btn_db;
   logic             press;
   logic             press_ok;
   logic [WIDTH-1:0] conta_nxt;
   logic             ovf_nxt;

   antirrebote #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_antirrebote (
      .clk     (clk),
      .reset_i (reset_i),
      .raw     (boton_i),
      .nivel   (btn_db),
      .pulso   (press)
   );

   assign pulso_o  = press;
   // The rise pulse always coincides with a high debounced level
   assign press_ok = press & btn_db;

   // Next count: load wins over a coincident press, limits wrap or hold
   always_comb begin
      conta_nxt = conta_o;
      ovf_nxt   = 1'b0;
      if (load_i) begin
         conta_nxt = dato_i;
         ovf_nxt   = 1'b0;
      end else if (press_ok) begin
         case (dir_t'(dir_i))
            DIR_UP: begin
               if (conta_o == MAXIMO) begin
                  if (SATURATE) begin
                     conta_nxt = MAXIMO;
                  end else begin
                     conta_nxt = CERO;
                  end
                  ovf_nxt = 1'b1;
               end else begin
                  conta_nxt = conta_o + UNO;
                  ovf_nxt   = 1'b0;
               end
            end
            DIR_DOWN: begin
               if (conta_o == CERO) begin
                  if (SATURATE) begin
                     conta_nxt = CERO;
                  end else begin
                     conta_nxt = MAXIMO;
                  end
                  ovf_nxt = 1'b1;
               end else begin
                  conta_nxt = conta_o - UNO;
                  ovf_nxt   = 1'b0;
               end
            end
            default: begin
               conta_nxt = conta_o;
               ovf_nxt   = 1'b0;
            end
         endcase
      end else begin
         conta_nxt = conta_o;
         ovf_nxt   = 1'b0;
      end
   end

   // Count and overflow flag registers
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         conta_o <= CERO;
         ovf_o   <= 1'b0;
      end else begin
         conta_o <= conta_nxt;
         ovf_o   <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: a wrapping and a saturating instance share
// all stimulus and are checked against hand-computed values.
module tb_contador_param;

   localparam int D          = 4;
   localparam int PULSE_STEP = D + 3;
   localparam int UPD_STEP   = D + 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       boton = 1'b0;
   logic       dir = 1'b0;
   logic       load = 1'b0;
   logic [7:0] dato = 8'h00;
   logic [7:0] conta0, conta1;
   logic       pulso0, pulso1, ovf0, ovf1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   contador_param #(.WIDTH(8), .DEBOUNCE_CYC(D), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset_i(reset), .boton_i(boton), .dir_i(dir), .load_i(load),
      .dato_i(dato), .conta_o(conta0), .pulso_o(pulso0), .ovf_o(ovf0));

   contador_param #(.WIDTH(8), .DEBOUNCE_CYC(D), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset_i(reset), .boton_i(boton), .dir_i(dir), .load_i(load),
      .dato_i(dato), .conta_o(conta1), .pulso_o(pulso1), .ovf_o(ovf1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the button for 'hold' steps; step k samples just after edge E0+k-1.
   task automatic press(input int hold, output int first0, output int np0, output int np1,
                        output int novf0, output int novf1,
                        output logic [7:0] c0u, output logic [7:0] c1u,
                        output logic o0u, output logic o1u, output logic o0a, output logic o1a);
      boton = 1'b1;
      first0 = 0; np0 = 0; np1 = 0; novf0 = 0; novf1 = 0;
      c0u = 8'h00; c1u = 8'h00; o0u = 1'b0; o1u = 1'b0; o0a = 1'b0; o1a = 1'b0;
      for (int k = 1; k <= hold; k++) begin
         step();
         if (pulso0) begin
            np0++;
            if (first0 == 0) first0 = k;
         end
         if (pulso1) np1++;
         if (ovf0) novf0++;
         if (ovf1) novf1++;
         if (k == UPD_STEP) begin
            c0u = conta0; c1u = conta1; o0u = ovf0; o1u = ovf1;
         end
         if (k == UPD_STEP + 1) begin
            o0a = ovf0; o1a = ovf1;
         end
      end
   endtask

   task automatic release_btn(input int cycles, output int np);
      boton = 1'b0;
      np = 0;
      for (int k = 0; k < cycles; k++) begin
         step();
         if (pulso0 || pulso1) np++;
      end
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1;
      dato = v;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      tests++;
      if (conta0 !== 8'h00 || pulso0 !== 1'b0 || ovf0 !== 1'b0 ||
          conta1 !== 8'h00 || pulso1 !== 1'b0 || ovf1 !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got conta=%h/%h pulso=%b/%b ovf=%b/%b, want all 0",
                  conta0, conta1, pulso0, pulso1, ovf0, ovf1);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_clean_presses();
      int f, n0, n1, v0, v1, nr;
      logic [7:0] c0, c1;
      logic o0, o1, a0, a1;
      dir = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         press(10, f, n0, n1, v0, v1, c0, c1, o0, o1, a0, a1);
         tests++;
         if (f !== PULSE_STEP || n0 !== 1 || n1 !== 1) begin
            fails++;
            $display("FAIL clean_pulse%0d: got first=%0d n=%0d/%0d, want first=%0d n=1/1",
                     i, f, n0, n1, PULSE_STEP);
         end
         tests++;
         if (c0 !== 8'(i) || c1 !== 8'(i) || v0 !== 0 || v1 !== 0) begin
            fails++;
            $display("FAIL clean_count%0d: got conta=%h/%h ovf_cycles=%0d/%0d, want %h, 0",
                     i, c0, c1, v0, v1, 8'(i));
         end
         release_btn(10, nr);
         tests++;
         if (nr !== 0) begin
            fails++;
            $display("FAIL release_pulse%0d: got %0d pulses, want 0", i, nr);
         end
      end
   endtask

   task automatic test_glitch_bounce();
      int f, n0, n1, v0, v1, nr, ng;
      logic [7:0] c0, c1;
      logic o0, o1, a0, a1;
      ng = 0;
      boton = 1'b1;
      step(); if (pulso0 || pulso1) ng++;
      step(); if (pulso0 || pulso1) ng++;
      release_btn(10, nr);
      tests++;
      if (ng + nr !== 0 || conta0 !== 8'h03) begin
         fails++;
         $display("FAIL glitch: got %0d pulses conta=%h, want 0 pulses conta=03", ng + nr, conta0);
      end
      ng = 0;
      for (int k = 0; k < 4; k++) begin
         boton = (k % 2 == 0) ? 1'b1 : 1'b0;
         step();
         if (pulso0 || pulso1) ng++;
      end
      press(12, f, n0, n1, v0, v1, c0, c1, o0, o1, a0, a1);
      tests++;
      if (ng !== 0 || f !== PULSE_STEP || n0 !== 1 || c0 !== 8'h04 || c1 !== 8'h04) begin
         fails++;
         $display("FAIL bounce: got bounce_pulses=%0d first=%0d n=%0d conta=%h/%h, want 0 %0d 1 04/04",
                  ng, f, n0, c0, c1, PULSE_STEP);
      end
      release_btn(10, nr);
   endtask

   task automatic test_limits();
      int f, n0, n1, v0, v1, nr;
      logic [7:0] c0, c1;
      logic o0, o1, a0, a1;
      dir = 1'b0;
      do_load(8'hFF);
      tests++;
      if (conta0 !== 8'hFF || conta1 !== 8'hFF || ovf0 !== 1'b0) begin
         fails++;
         $display("FAIL load_ff: got conta=%h/%h ovf=%b, want ff/ff 0", conta0, conta1, ovf0);
      end
      press(10, f, n0, n1, v0, v1, c0, c1, o0, o1, a0, a1);
      tests++;
      if (c0 !== 8'h00 || o0 !== 1'b1 || a0 !== 1'b0 || v0 !== 1) begin
         fails++;
         $display("FAIL wrap_up: got conta=%h ovf=%b next_ovf=%b ovf_cycles=%0d, want 00 1 0 1",
                  c0, o0, a0, v0);
      end
      tests++;
      if (c1 !== 8'hFF || o1 !== 1'b1 || a1 !== 1'b0 || v1 !== 1) begin
         fails++;
         $display("FAIL sat_up1: got conta=%h ovf=%b next_ovf=%b ovf_cycles=%0d, want ff 1 0 1",
                  c1, o1, a1, v1);
      end
      release_btn(10, nr);
      press(10, f, n0, n1, v0, v1, c0, c1, o0, o1, a0, a1);
      tests++;
      if (c0 !== 8'h01 || o0 !== 1'b0 || c1 !== 8'hFF || o1 !== 1'b1) begin
         fails++;
         $display("FAIL sat_up2: got conta=%h/%h ovf=%b/%b, want 01/ff 0/1", c0, c1, o0, o1);
      end
      release_btn(10, nr);
      do_load(8'h00);
      dir = 1'b1;
      press(10, f, n0, n1, v0, v1, c0, c1, o0, o1, a0, a1);
      tests++;
      if (c0 !== 8'hFF || o0 !== 1'b1 || a0 !== 1'b0) begin
         fails++;
         $display("FAIL wrap_down: got conta=%h ovf=%b next_ovf=%b, want ff 1 0", c0, o0, a0);
      end
      tests++;
      if (c1 !== 8'h00 || o1 !== 1'b1 || a1 !== 1'b0) begin
         fails++;
         $display("FAIL sat_down: got conta=%h ovf=%b next_ovf=%b, want 00 1 0", c1, o1, a1);
      end
      release_btn(10, nr);
   endtask

   task automatic test_load_press();
      int nr, extra;
      logic p;
      // dut_wrap sits at ff, dut_sat at 00: a down press would change one and flag the other
      dir = 1'b1;
      boton = 1'b1;
      for (int k = 1; k <= PULSE_STEP; k++) step();
      p = pulso0;
      load = 1'b1;
      dato = 8'h5A;
      step();
      load = 1'b0;
      tests++;
      if (p !== 1'b1 || conta0 !== 8'h5A || conta1 !== 8'h5A || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
         fails++;
         $display("FAIL load_vs_press: got pulso=%b conta=%h/%h ovf=%b/%b, want 1 5a/5a 0/0",
                  p, conta0, conta1, ovf0, ovf1);
      end
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (conta0 !== 8'h5A || conta1 !== 8'h5A) extra++;
      end
      tests++;
      if (extra !== 0) begin
         fails++;
         $display("FAIL load_hold: got %0d cycles with conta!=5a (now %h/%h), want 0", extra, conta0, conta1);
      end
      release_btn(10, nr);
      dir = 1'b0;
   endtask

   task automatic test_reset_mid();
      int early;
      boton = 1'b1;
      step(); step(); step();
      reset = 1'b1;
      #1;
      tests++;
      if (conta0 !== 8'h00 || conta1 !== 8'h00 || pulso0 !== 1'b0 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: got conta=%h/%h pulso=%b ovf=%b/%b, want all 0",
                  conta0, conta1, pulso0, ovf0, ovf1);
      end
      step(); step();
      reset = 1'b0;
      early = 0;
      for (int k = 1; k <= UPD_STEP + 2; k++) begin
         step();
         if (k < PULSE_STEP && (pulso0 || conta0 !== 8'h00)) early++;
         if (k == PULSE_STEP) begin
            tests++;
            if (pulso0 !== 1'b1 || conta0 !== 8'h00) begin
               fails++;
               $display("FAIL reset_repress_pulse: got pulso=%b conta=%h, want 1 00", pulso0, conta0);
            end
         end
         if (k == UPD_STEP) begin
            tests++;
            if (conta0 !== 8'h01 || conta1 !== 8'h01) begin
               fails++;
               $display("FAIL reset_repress_count: got conta=%h/%h, want 01/01", conta0, conta1);
            end
         end
      end
      tests++;
      if (early !== 0) begin
         fails++;
         $display("FAIL reset_early: got %0d early events, want 0", early);
      end
      boton = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_presses();
      test_glitch_bounce();
      test_limits();
      test_load_press();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
